vga_timing_gen: RTL and testbench

- Pixel-timing core for the text-mode GPU: it turns the system clock into a pixel-rate strobe and produces VGA 640x480@60 sync and position signals.
- It generates h_sync, v_sync, active, pixel coordinates and a one-shot blanking-start pulse.
- Consumers are the GPU's text RAM/font ROM pipeline and its frame interrupt logic.
- Single clock domain. Any pixel-rate slowdown uses a clock-enable strobe, never a derived clock.

---
 rtl/vga_timing_gen.sv | 113 +++++++++++
 tb/tb_vga_timing_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Pixel-timing core for the text-mode GPU. A clock-enable strobe (pix_tick)
// is derived from the system clock, and horizontal/vertical counters step on
// that strobe to produce VGA sync, visible-area and position signals. A
// one-clock pulse marks the first pixel of vertical blanking so the frame
// interrupt logic can latch it without edge detection of its own.
//
// Ports:
//   clk            : system clock, all state changes on its rising edge
//   rst_n          : asynchronous active-low reset
//   pix_tick       : pixel strobe, counters advance on edges where it is 1
//   x              : horizontal pixel counter, 0..H_TOTAL-1
//   y              : vertical line counter, 0..V_TOTAL-1
//   h_sync         : horizontal sync, asserted level = SYNC_POL
//   v_sync         : vertical sync, asserted level = SYNC_POL
//   active         : current (x,y) lies in the visible area
//   blanking_start : one-clk pulse at the first pixel of vertical blanking
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV  = 1,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       h_sync,
    output logic       v_sync,
    output logic       active,
    output logic       blanking_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

    // Sync windows are compared in 11 bits so an end boundary of exactly
    // 1024 (sync running to the end of a 1024-wide line) stays representable.
    localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [3:0]  div_cnt;
    logic        tick_en;
    logic [10:0] x_ext;
    logic [10:0] y_ext;

    assign tick_en = (div_cnt == DIV_LAST);
    assign x_ext   = {1'b0, x};
    assign y_ext   = {1'b0, y};

    // Clock divider: free-running modulo-CLK_DIV counter. The strobe fires
    // on its last count so the first tick after reset lands CLK_DIV-1 edges
    // after release (immediately when CLK_DIV is 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 4'd0;
        end else if (tick_en) begin
            div_cnt <= 4'd0;
        end else begin
            div_cnt <= div_cnt + 4'd1;
        end
    end

    // Raster counters: x steps every tick, y steps when x wraps. The frame
    // wrap from the last pixel back to (0,0) takes a single tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= 10'd0;
            y <= 10'd0;
        end else if (tick_en) begin
            if (x == H_LAST) begin
                x <= 10'd0;
                if (y == V_LAST) begin
                    y <= 10'd0;
                end else begin
                    y <= y + 10'd1;
                end
            end else begin
                x <= x + 10'd1;
            end
        end
    end

    // Decodes of the registered counters. pix_tick and blanking_start are
    // gated by rst_n so nothing downstream sees a strobe while held in reset
    // (with CLK_DIV=1 the divider compare alone would otherwise read 1).
    always_comb begin
        pix_tick       = rst_n && tick_en;
        active         = (x_ext < H_VIS_END) && (y_ext < V_VIS_END);
        h_sync         = ((x_ext >= H_SYNC_BEG) && (x_ext < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        v_sync         = ((y_ext >= V_SYNC_BEG) && (y_ext < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        blanking_start = pix_tick && (x == 10'd0) && (y_ext == V_VIS_END);
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Self-checking bench for vga_timing_gen. Two instances share clock and
// reset:
//   dut0 : CLK_DIV=1, default 800-pixel lines, shortened 27-line frame
//          (frame = 21600 clks) so full-frame behaviour stays short.
//   dut1 : CLK_DIV=4, tiny 16x10 raster, active-high syncs (frame = 640 clks).
// A raster model computes expected outputs from the number of clock edges
// seen since reset release; directed literal checks pin the model itself.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic       clk;
    logic       rst_n;

    logic       tick0, hs0, vs0, act0, bs0;
    logic [9:0] x0, y0;
    logic       tick1, hs1, vs1, act1, bs1;
    logic [9:0] x1, y1;

    int  checks = 0;
    int  errors = 0;
    longint edges = 0;

    vga_timing_gen #(
        .CLK_DIV(1),
        .V_ACTIVE(20), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .pix_tick(tick0), .x(x0), .y(y0),
        .h_sync(hs0), .v_sync(vs0), .active(act0), .blanking_start(bs0)
    );

    vga_timing_gen #(
        .CLK_DIV(4),
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_POL(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .pix_tick(tick1), .x(x1), .y(y1),
        .h_sync(hs1), .v_sync(vs1), .active(act1), .blanking_start(bs1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count of rising edges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    // Raster model: ticks seen = edges / div, position = ticks mod frame.
    // Packed result {tick, blank_start, active, h_sync, v_sync, x, y}.
    function automatic logic [24:0] model_out(input longint e, input int d,
        input int ha, input int hf, input int hs, input int hb,
        input int va, input int vf, input int vs, input int vb,
        input bit pol, input logic rn);
        int     ht;
        int     vt;
        longint p;
        int     xm;
        int     ym;
        logic   t, b, a, h, v;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        p  = (e / d) % (ht * vt);
        xm = int'(p % ht);
        ym = int'(p / ht);
        t  = rn && ((e % d) == d - 1);
        b  = t && (xm == 0) && (ym == va);
        a  = (xm < ha) && (ym < va);
        h  = (xm >= ha + hf && xm < ha + hf + hs) ? pol : ~pol;
        v  = (ym >= va + vf && ym < va + vf + vs) ? pol : ~pol;
        return {t, b, a, h, v, 10'(xm), 10'(ym)};
    endfunction

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, actual, expected, edges, $time);
        end
    endtask

    // Continuous compare of both instances against the model each cycle.
    always @(negedge clk) begin
        check_output("dut0_raster", longint'({tick0, bs0, act0, hs0, vs0, x0, y0}),
                     longint'(model_out(edges, 1, 640, 16, 96, 48, 20, 2, 2, 3, 1'b0, rst_n)));
        check_output("dut1_raster", longint'({tick1, bs1, act1, hs1, vs1, x1, y1}),
                     longint'(model_out(edges, 4, 8, 2, 3, 3, 6, 1, 2, 1, 1'b1, rst_n)));
    end

    task automatic apply_stimulus(input logic rn, input int cycles);
        repeat (cycles) @(negedge clk);
        #2 rst_n = rn;
    endtask

    initial begin
        int     hs_low;
        int     vs_low;
        int     ticks1;
        int     bs1_count;
        longint bs0_first;
        longint bs0_second;
        longint bs1_first;
        bit     found;

        hs_low = 0; vs_low = 0; ticks1 = 0; bs1_count = 0;
        bs0_first = -1; bs0_second = -1; bs1_first = -1;

        // Reset held across several clock edges.
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_output("reset_x", longint'(x0), 0);
        check_output("reset_y", longint'(y0), 0);
        check_output("reset_hsync", longint'(hs0), 1);
        check_output("reset_vsync", longint'(vs0), 1);
        check_output("reset_active", longint'(act0), 1);
        check_output("reset_tick", longint'(tick0), 0);
        check_output("reset_blank", longint'(bs0), 0);
        check_output("reset_hsync_pol1", longint'(hs1), 0);

        // Release and run two dut0 frames with directed observations.
        apply_stimulus(1'b1, 1);
        for (int i = 0; i < 43250; i++) begin
            @(negedge clk);
            if (edges == 1) begin
                check_output("first_edge_x", longint'(x0), 1);
                check_output("first_edge_tick1", longint'(tick1), 0);
            end
            if (edges == 639) check_output("active_at_639", longint'(act0), 1);
            if (edges == 640) check_output("active_at_640", longint'(act0), 0);
            if (edges == 800) begin
                check_output("line_wrap_x", longint'(x0), 0);
                check_output("line_wrap_y", longint'(y0), 1);
            end
            if (edges == 21599) begin
                check_output("frame_end_x", longint'(x0), 799);
                check_output("frame_end_y", longint'(y0), 26);
            end
            if (edges == 21600) check_output("frame_wrap_xy", longint'({x0, y0}), 0);
            if (edges < 800 && hs0 == 1'b0) hs_low++;
            if (edges < 21600 && vs0 == 1'b0) vs_low++;
            if (edges <= 400 && tick1) ticks1++;
            if (edges <= 1030 && bs1) bs1_count++;
            if (bs0 && bs0_first < 0) bs0_first = edges;
            else if (bs0 && bs0_second < 0) bs0_second = edges;
            if (bs1 && bs1_first < 0) bs1_first = edges;
        end
        check_output("hsync_low_cycles", hs_low, 96);
        check_output("vsync_low_cycles", vs_low, 1600);
        check_output("blank0_first_edge", bs0_first, 16000);
        check_output("blank0_period", bs0_second - bs0_first, 21600);
        check_output("div4_tick_count", ticks1, 100);
        check_output("blank1_first_edge", bs1_first, 387);
        check_output("blank1_pulse_count", bs1_count, 2);

        // Mid-frame reset at dut0 (300,2), asserted between clock edges.
        found = 1'b0;
        for (int i = 0; i < 30000 && !found; i++) begin
            @(negedge clk);
            if (x0 == 10'd300 && y0 == 10'd2) found = 1'b1;
        end
        check_output("midframe_reached", longint'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_clear_dut0", longint'({x0, y0}), 0);
        check_output("async_clear_dut1", longint'({x1, y1}), 0);
        check_output("async_clear_tick", longint'({tick0, tick1}), 0);

        // After release, timing restarts exactly as after power-up.
        apply_stimulus(1'b1, 3);
        bs0_first = -1;
        for (int i = 0; i < 16010; i++) begin
            @(negedge clk);
            if (edges == 1) check_output("restart_first_x", longint'(x0), 1);
            if (bs0 && bs0_first < 0) bs0_first = edges;
        end
        check_output("restart_blank_edge", bs0_first, 16000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
